legv8_main_ctrl_fsm: RTL and testbench

//  Multi-cycle main control unit for the LEGv8 core. Decodes the 11-bit opcode field
//  of the instruction register and sequences fetch/decode/execute/memory/writeback,

---
 rtl/legv8_main_ctrl_fsm.sv | 259 +++++++++++++++++++++++++
 tb/tb_legv8_main_ctrl_fsm.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_main_ctrl_fsm.sv
// legv8_main_ctrl_fsm: multi-cycle main control for the LEGv8 core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables and the
// 2-bit alu_op for the ALU control stage, and counts retired instructions.
// Optional build macro LEGV8_CTRL_ILLEGAL_TRAP_EN: adds output illegal_op and
// a terminal TRAP state for undecodable opcodes. Without it, an illegal opcode
// retires as a NOP straight out of DECODE.
//
// state  | meaning
// -------+-------------------------------------------------------------------
// FETCH  | read instruction memory, wait for mem_ready, load IR and PC+4
// DECODE | classify opcode, drive alu_op early for the registered ALU control
// EXEC   | ALU op / address calc / branch resolve (CBZ, B retire here)
// MEM    | LDUR read or STUR write, wait for mem_ready (STUR retires here)
// WB     | register file write (ALU result or load data)
// TRAP   | illegal opcode seen; all controls low until reset (macro builds)

module legv8_main_ctrl_fsm #(
  parameter int CNT_W    = 32,
  parameter int OPCODE_W = 11
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg2loc,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [CNT_W-1:0]    retire_count
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_op
`endif
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
    ,
    ST_TRAP   = 3'd5
`endif
  } state_t;

  typedef enum logic [2:0] {
    CL_R    = 3'd0,
    CL_LDUR = 3'd1,
    CL_STUR = 3'd2,
    CL_CBZ  = 3'd3,
    CL_B    = 3'd4,
    CL_ILL  = 3'd5
  } iclass_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_PASS = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  state_t     state_q, state_d;
  iclass_t    class_q, dec_class;
  logic       retire;
  logic [10:0] op_field;

  // The fixed encodings below are defined on the top 11 opcode bits.
  assign op_field = opcode[10:0];

  // Opcode classification; only consumed while in DECODE.
  always_comb begin
    dec_class = CL_ILL;
    case (op_field)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec_class = CL_R;
      11'b11111000010: dec_class = CL_LDUR;
      11'b11111000000: dec_class = CL_STUR;
      default: begin
        if (op_field[10:3] == 8'b10110100) begin
          dec_class = CL_CBZ;
        end else if (op_field[10:5] == 6'b000101) begin
          dec_class = CL_B;
        end
      end
    endcase
  end

  // State register; reset overrides any pending transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction class is captured on the way out of DECODE.
  always_ff @(posedge clock) begin
    if (reset) begin
      class_q <= CL_ILL;
    end else if (state_q == ST_DECODE) begin
      class_q <= dec_class;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_count <= '0;
    end else if (retire) begin
      retire_count <= retire_count + 1'b1;
    end
  end

  // Next-state and control outputs; every output is forced low during reset.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif

    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (dec_class)
          CL_R:    alu_op = ALU_FUNC;
          CL_CBZ:  alu_op = ALU_PASS;
          default: alu_op = ALU_ADD;
        endcase
        if (dec_class == CL_ILL) begin
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
          retire  = 1'b1;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (class_q)
          CL_R: begin
            alu_op  = ALU_FUNC;
            state_d = ST_WB;
          end
          CL_LDUR: begin
            alu_src = 1'b1;
            state_d = ST_MEM;
          end
          CL_STUR: begin
            alu_src = 1'b1;
            reg2loc = 1'b1;
            state_d = ST_MEM;
          end
          CL_CBZ: begin
            alu_op   = ALU_PASS;
            reg2loc  = 1'b1;
            pc_src   = 1'b1;
            pc_write = alu_zero;
            state_d  = ST_FETCH;
            retire   = 1'b1;
          end
          CL_B: begin
            pc_src   = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_FETCH;
            retire   = 1'b1;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        alu_src = 1'b1;
        if (class_q == CL_STUR) begin
          mem_write = 1'b1;
          reg2loc   = 1'b1;
        end else begin
          mem_read = 1'b1;
        end
        if (mem_ready) begin
          if (class_q == CL_STUR) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        if (class_q == CL_LDUR) begin
          mem_to_reg = 1'b1;
          alu_src    = 1'b1;
        end else begin
          alu_op = ALU_FUNC;
        end
        state_d = ST_FETCH;
        retire  = 1'b1;
      end

`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: begin
        illegal_op = 1'b1;
      end
`endif

      default: state_d = ST_FETCH;
    endcase

    if (reset) begin
      retire     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
      illegal_op = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_legv8_main_ctrl_fsm.sv
// Testbench for legv8_main_ctrl_fsm: table of single instructions, a few
// hand-built multi-cycle sequences, and a randomized instruction stream
// checked cycle-by-cycle against a per-instruction phase model.
`timescale 1ns/1ps
module tb_legv8_main_ctrl_fsm;
  localparam int CNT_W = 4;
  localparam int OPW   = 11;

  localparam int C_R    = 0;
  localparam int C_LDUR = 1;
  localparam int C_STUR = 2;
  localparam int C_CBZ  = 3;
  localparam int C_B    = 4;
  localparam int C_ILL  = 5;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [OPW-1:0] opcode = '0;
  logic alu_zero = 1'b0;
  logic mem_ready = 1'b0;
  logic ir_write, pc_write, pc_src, reg2loc, alu_src;
  logic [1:0] alu_op;
  logic mem_read, mem_write, mem_to_reg, reg_write;
  logic [CNT_W-1:0] retire_count;
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
  logic illegal_op;
`endif
  logic [10:0] outs;

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;

  legv8_main_ctrl_fsm #(.CNT_W(CNT_W), .OPCODE_W(OPW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .retire_count(retire_count)
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clock = ~clock;

  assign outs = {ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op,
                 mem_read, mem_write, mem_to_reg, reg_write};

  // Expected control vector, same bit order as outs.
  function automatic logic [10:0] mk(input logic ir, input logic pcw, input logic pcs,
                                     input logic r2l, input logic asrc, input logic [1:0] aop,
                                     input logic mr, input logic mw, input logic m2r,
                                     input logic rw);
    return {ir, pcw, pcs, r2l, asrc, aop, mr, mw, m2r, rw};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [10:0] ro();
    return 11'($urandom);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        mr;
    logic        z;
    logic [10:0] opc;
    logic [10:0] exp;
    logic        ret;
  } cyc_t;

  cyc_t trace[$];

  task automatic put(input logic mr, input logic z, input logic [10:0] opc,
                     input logic [10:0] exp, input logic ret);
    cyc_t c;
    c.mr = mr; c.z = z; c.opc = opc; c.exp = exp; c.ret = ret;
    trace.push_back(c);
  endtask

  // Phase model: one instruction expands into its per-cycle control pattern.
  // fw/mw are memory wait cycles in FETCH/MEM; don't-care inputs are random.
  task automatic gen_instr(input int cls, input logic [10:0] op, input int fw,
                           input int mw, input logic z);
    logic [1:0] aop;
    for (int k = 0; k < fw; k++) put(1'b0, rb(), ro(), mk(0,0,0,0,0,2'b00,1,0,0,0), 1'b0);
    put(1'b1, rb(), ro(), mk(1,1,0,0,0,2'b00,1,0,0,0), 1'b0);
    aop = (cls == C_R) ? 2'b10 : (cls == C_CBZ) ? 2'b01 : 2'b00;
    put(rb(), rb(), op, mk(0,0,0,0,0,aop,0,0,0,0), cls == C_ILL);
    case (cls)
      C_R: begin
        put(rb(), rb(), ro(), mk(0,0,0,0,0,2'b10,0,0,0,0), 1'b0);
        put(rb(), rb(), ro(), mk(0,0,0,0,0,2'b10,0,0,0,1), 1'b1);
      end
      C_LDUR: begin
        put(rb(), rb(), ro(), mk(0,0,0,0,1,2'b00,0,0,0,0), 1'b0);
        for (int k = 0; k < mw; k++) put(1'b0, rb(), ro(), mk(0,0,0,0,1,2'b00,1,0,0,0), 1'b0);
        put(1'b1, rb(), ro(), mk(0,0,0,0,1,2'b00,1,0,0,0), 1'b0);
        put(rb(), rb(), ro(), mk(0,0,0,0,1,2'b00,0,0,1,1), 1'b1);
      end
      C_STUR: begin
        put(rb(), rb(), ro(), mk(0,0,0,1,1,2'b00,0,0,0,0), 1'b0);
        for (int k = 0; k < mw; k++) put(1'b0, rb(), ro(), mk(0,0,0,1,1,2'b00,0,1,0,0), 1'b0);
        put(1'b1, rb(), ro(), mk(0,0,0,1,1,2'b00,0,1,0,0), 1'b1);
      end
      C_CBZ: put(rb(), z, ro(), mk(0,z,1,1,0,2'b01,0,0,0,0), 1'b1);
      C_B:   put(rb(), rb(), ro(), mk(0,1,1,0,0,2'b00,0,0,0,0), 1'b1);
      default: ;
    endcase
  endtask

  // Apply the queued cycles; starts just after a negedge, ends at the next one.
  task automatic run_trace(input string tag);
    cyc_t c;
    while (trace.size() > 0) begin
      c = trace.pop_front();
      mem_ready = c.mr;
      alu_zero  = c.z;
      opcode    = c.opc;
      #1;
      chk($sformatf("%s ctrl", tag), 32'(outs), 32'(c.exp));
      chk($sformatf("%s retire_count", tag), 32'(retire_count), 32'(model_cnt));
      if (c.ret) model_cnt = (model_cnt + 1) % (1 << CNT_W);
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; mem_ready = 1'b1; opcode = ro(); alu_zero = rb();
    #1 chk("reset ctrl", 32'(outs), 32'd0);
    @(negedge clock);
    #1 chk("reset ctrl hold", 32'(outs), 32'd0);
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
    chk("reset illegal_op", 32'(illegal_op), 32'd0);
`endif
    @(negedge clock);
    reset = 1'b0; mem_ready = 1'b0; model_cnt = 0;
    #1;
    chk("reset retire_count", 32'(retire_count), 32'd0);
    chk("post-reset fetch", 32'(outs), 32'(mk(0,0,0,0,0,2'b00,1,0,0,0)));
  endtask

  typedef struct {
    string       name;
    logic [10:0] op;
    logic        z;
    int          lat;
    logic [1:0]  dec_aop;
    logic        rw;
    logic        mw;
    logic        br;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mv(input string name, input logic [10:0] op, input logic z,
                              input int lat, input logic [1:0] dec_aop, input logic rw,
                              input logic mw, input logic br);
    vec_t v;
    v.name = name; v.op = op; v.z = z; v.lat = lat; v.dec_aop = dec_aop;
    v.rw = rw; v.mw = mw; v.br = br;
    return v;
  endfunction

  initial begin
    int lat;
    logic [1:0] dec_aop;
    logic seen_rw, seen_mw, seen_br;
    int cls;
    logic [10:0] op;
    logic [10:0] ill_ops [4];

    tbl.push_back(mv("ADD",   OP_ADD,  1'b0, 4, 2'b10, 1, 0, 0));
    tbl.push_back(mv("SUB",   OP_SUB,  1'b1, 4, 2'b10, 1, 0, 0));
    tbl.push_back(mv("AND",   OP_AND,  1'b0, 4, 2'b10, 1, 0, 0));
    tbl.push_back(mv("ORR",   OP_ORR,  1'b0, 4, 2'b10, 1, 0, 0));
    tbl.push_back(mv("LDUR",  OP_LDUR, 1'b0, 5, 2'b00, 1, 0, 0));
    tbl.push_back(mv("STUR",  OP_STUR, 1'b0, 4, 2'b00, 0, 1, 0));
    tbl.push_back(mv("CBZ_nz", 11'b10110100101, 1'b0, 3, 2'b01, 0, 0, 0));
    tbl.push_back(mv("CBZ_z",  11'b10110100000, 1'b1, 3, 2'b01, 0, 0, 1));
    tbl.push_back(mv("B",     11'b00010100000, 1'b0, 3, 2'b00, 0, 0, 1));
    tbl.push_back(mv("B_ones", 11'b00010111111, 1'b1, 3, 2'b00, 0, 0, 1));
`ifndef LEGV8_CTRL_ILLEGAL_TRAP_EN
    tbl.push_back(mv("ILL_all1", 11'b11111111111, 1'b0, 2, 2'b00, 0, 0, 0));
    tbl.push_back(mv("ILL_add1", 11'b10001011001, 1'b0, 2, 2'b00, 0, 0, 0));
    tbl.push_back(mv("ILL_cbzx", 11'b10110101000, 1'b1, 2, 2'b00, 0, 0, 0));
    tbl.push_back(mv("ILL_bx",   11'b00010011111, 1'b0, 2, 2'b00, 0, 0, 0));
`endif

    do_reset();

    // Single instructions, zero-wait memory: latency and key enables.
    foreach (tbl[i]) begin
      lat = -1; dec_aop = 2'bxx; seen_rw = 1'b0; seen_mw = 1'b0; seen_br = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (c > 0) @(negedge clock);
        opcode = tbl[i].op; mem_ready = 1'b1; alu_zero = tbl[i].z;
        #1;
        if (c == 0) begin
          chk({tbl[i].name, " fetch ir_write"}, 32'(ir_write), 32'd1);
          chk({tbl[i].name, " start retire_count"}, 32'(retire_count), 32'(model_cnt));
        end
        if (c == 1) dec_aop = alu_op;
        if (c > 0 && ir_write) begin
          lat = c;
          break;
        end
        seen_rw |= reg_write;
        seen_mw |= mem_write;
        if (c > 0) seen_br |= pc_write;
      end
      chk({tbl[i].name, " latency"}, 32'(lat), 32'(tbl[i].lat));
      chk({tbl[i].name, " decode alu_op"}, 32'(dec_aop), 32'(tbl[i].dec_aop));
      chk({tbl[i].name, " reg_write seen"}, 32'(seen_rw), 32'(tbl[i].rw));
      chk({tbl[i].name, " mem_write seen"}, 32'(seen_mw), 32'(tbl[i].mw));
      chk({tbl[i].name, " branch pc_write"}, 32'(seen_br), 32'(tbl[i].br));
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
    end
    #1 chk("table end retire_count", 32'(retire_count), 32'(model_cnt));
    @(negedge clock);
    model_cnt = model_cnt;

    // The FETCH cycle left over from the table loop is now consumed; resync.
    do_reset();

    // ADD with zero-wait memory, cycle by cycle.
    gen_instr(C_R, OP_ADD, 0, 0, 1'b0);
    run_trace("add");
    // LDUR with three MEM wait cycles.
    gen_instr(C_LDUR, OP_LDUR, 0, 3, 1'b0);
    run_trace("ldur_wait");
    // CBZ not-taken then taken.
    gen_instr(C_CBZ, 11'b10110100011, 0, 0, 1'b0);
    gen_instr(C_CBZ, 11'b10110100110, 0, 0, 1'b1);
    run_trace("cbz");
    // STUR then B back to back.
    do_reset();
    gen_instr(C_STUR, OP_STUR, 0, 0, 1'b0);
    gen_instr(C_B, 11'b00010101010, 0, 0, 1'b0);
    run_trace("stur_b");
    #1 chk("stur_b retire_count", 32'(retire_count), 32'd2);

    // Reset in MEM of LDUR together with mem_ready: no writeback, count cleared.
    opcode = OP_LDUR; mem_ready = 1'b1;
    #1 chk("rst_mem fetch", 32'(outs), 32'(mk(1,1,0,0,0,2'b00,1,0,0,0)));
    @(negedge clock); opcode = OP_LDUR; mem_ready = 1'b0;
    #1 chk("rst_mem decode", 32'(outs), 32'(mk(0,0,0,0,0,2'b00,0,0,0,0)));
    @(negedge clock); opcode = ro();
    #1 chk("rst_mem exec", 32'(outs), 32'(mk(0,0,0,0,1,2'b00,0,0,0,0)));
    @(negedge clock); mem_ready = 1'b0;
    #1 chk("rst_mem mem", 32'(outs), 32'(mk(0,0,0,0,1,2'b00,1,0,0,0)));
    reset = 1'b1; mem_ready = 1'b1;
    #1 chk("rst_mem during reset", 32'(outs), 32'd0);
    @(negedge clock); reset = 1'b0; mem_ready = 1'b0; model_cnt = 0;
    #1 chk("rst_mem next is fetch", 32'(outs), 32'(mk(0,0,0,0,0,2'b00,1,0,0,0)));
    chk("rst_mem retire_count", 32'(retire_count), 32'd0);
    @(negedge clock);
    #1 chk("rst_mem no wb", 32'(reg_write), 32'd0);
    @(negedge clock);

`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
    // Illegal opcode traps until reset.
    do_reset();
    gen_instr(C_R, OP_SUB, 1, 0, 1'b0);
    run_trace("pre_trap");
    mem_ready = 1'b1; opcode = ro();
    #1 chk("trap fetch", 32'(ir_write), 32'd1);
    @(negedge clock); opcode = 11'b11111111111;
    #1 chk("trap decode illegal_op", 32'(illegal_op), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); mem_ready = rb(); opcode = ro(); alu_zero = rb();
      #1;
      chk("trap illegal_op", 32'(illegal_op), 32'd1);
      chk("trap ctrl", 32'(outs), 32'd0);
      chk("trap retire_count", 32'(retire_count), 32'd1);
    end
    do_reset();
`endif

    // Randomized instruction stream; CNT_W=4 makes the counter wrap often.
    do_reset();
    ill_ops[0] = 11'b11111111111;
    ill_ops[1] = 11'b10001011001;
    ill_ops[2] = 11'b10110101000;
    ill_ops[3] = 11'b00000000000;
    for (int n = 0; n < 300; n++) begin
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
      cls = $urandom_range(4, 0);
`else
      cls = $urandom_range(5, 0);
`endif
      case (cls)
        C_R: begin
          case ($urandom_range(3, 0))
            0: op = OP_ADD;
            1: op = OP_SUB;
            2: op = OP_AND;
            default: op = OP_ORR;
          endcase
        end
        C_LDUR: op = OP_LDUR;
        C_STUR: op = OP_STUR;
        C_CBZ:  op = {8'b10110100, 3'($urandom)};
        C_B:    op = {6'b000101, 5'($urandom)};
        default: op = ill_ops[$urandom_range(3, 0)];
      endcase
      gen_instr(cls, op, ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0,
                ($urandom_range(2, 0) == 0) ? $urandom_range(4, 1) : 0, rb());
      run_trace("rand");
    end
    #1 chk("rand final retire_count", 32'(retire_count), 32'(model_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
